// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared types and constants for the data-memory access arbiter.
//   state_e : arbiter FSM encoding (IDLE / ACCESS / DONE)
//   owner_e : identifies which requester owns the memory port (OWN_CPU=0, OWN_EXT=1)
//   LAT_W   : width of the wait-cycle counter (RD_LAT is 0..7)
package dm_arb_pkg;

  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_e;

endpackage

// File: rtl/dm_access_arbiter_if.sv
// dm_access_arbiter_if: bundles the CPU, external-requester and DM macro signals of the arbiter.
//   cpu_*  : CPU load/store request, payload, read data, ack and stall
//   ext_*  : external requester (loader / debug port) request, payload, read data and ack
//   DM_*   : single data-memory port
//   modport slave  : arbiter view (requests and DM_Read_Data in; acks, rdata and DM drive out)
//   modport master : requester/memory view (the mirror image)
interface dm_access_arbiter_if #(
  parameter int data_size = 32,
  parameter int mem_size  = 16
);

  logic                 cpu_req;
  logic                 cpu_we;
  logic [mem_size-1:0]  cpu_addr;
  logic [data_size-1:0] cpu_wdata;
  logic [data_size-1:0] cpu_rdata;
  logic                 cpu_ack;
  logic                 cpu_stall;

  logic                 ext_req;
  logic                 ext_we;
  logic [mem_size-1:0]  ext_addr;
  logic [data_size-1:0] ext_wdata;
  logic [data_size-1:0] ext_rdata;
  logic                 ext_ack;

  logic [mem_size-1:0]  DM_Address;
  logic                 DM_enable;
  logic [data_size-1:0] DM_Write_Data;
  logic [data_size-1:0] DM_Read_Data;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_rdata, ext_ack,
    output DM_Address, DM_enable, DM_Write_Data,
    input  DM_Read_Data
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_rdata, ext_ack,
    input  DM_Address, DM_enable, DM_Write_Data,
    output DM_Read_Data
  );

endinterface

// File: rtl/dm_arb_grant.sv
// dm_arb_grant: combinational choice of the next memory-port owner.
//   cpu_req_i    : CPU request
//   ext_req_i    : external requester request
//   last_owner_i : owner of the most recent grant
//   grant_o      : winner (only meaningful when at least one request is high)
// Build option: define DM_ARB_ROUND_ROBIN_EN to break ties in favour of the requester that
// was not granted last; otherwise the CPU always wins a tie.
module dm_arb_grant
  import dm_arb_pkg::*;
(
  input  logic   cpu_req_i,
  input  logic   ext_req_i,
  input  owner_e last_owner_i,
  output owner_e grant_o
);

`ifdef DM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  always_comb begin
    grant_o = OWN_CPU;
    if (cpu_req_i && ext_req_i) begin
      // On a tie the external side only wins when alternation is enabled and the CPU went last.
      grant_o = (RR_EN && (last_owner_i == OWN_CPU)) ? OWN_EXT : OWN_CPU;
    end else if (ext_req_i) begin
      grant_o = OWN_EXT;
    end
  end

endmodule

// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: shares one data-memory port between the CPU load/store path and an
// external requester. Each access is sequenced with RD_LAT extra wait cycles, read data is
// captured into the owner's rdata register and a one-cycle ack is returned.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : dm_access_arbiter_if.slave (CPU side, external side, DM macro port)
// Parameters: data_size (word width), mem_size (word-address width), RD_LAT (0..7).
// Build option: DM_ARB_ROUND_ROBIN_EN selects alternating tie-break (see dm_arb_grant).
module dm_access_arbiter
  import dm_arb_pkg::*;
#(
  parameter int data_size = 32,
  parameter int mem_size  = 16,
  parameter int RD_LAT    = 1
)(
  input logic           clk,
  input logic           rst,
  dm_access_arbiter_if.slave bus
);

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  owner_e               last_owner_q, last_owner_d;
  owner_e               grant;
  logic                 we_q, we_d;
  logic [LAT_W-1:0]     cnt_q, cnt_d;
  logic [mem_size-1:0]  dm_addr_q, dm_addr_d;
  logic                 dm_en_q, dm_en_d;
  logic [data_size-1:0] dm_wdata_q, dm_wdata_d;
  logic [data_size-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [data_size-1:0] ext_rdata_q, ext_rdata_d;
  logic                 cpu_ack_w;
  logic                 ext_ack_w;

  dm_arb_grant u_grant (
    .cpu_req_i    (bus.cpu_req),
    .ext_req_i    (bus.ext_req),
    .last_owner_i (last_owner_q),
    .grant_o      (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_EXT;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      dm_addr_q    <= '0;
      dm_en_q      <= 1'b0;
      dm_wdata_q   <= '0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      dm_addr_q    <= dm_addr_d;
      dm_en_q      <= dm_en_d;
      dm_wdata_q   <= dm_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    dm_addr_d    = dm_addr_q;
    dm_en_d      = dm_en_q;
    dm_wdata_d   = dm_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.ext_req) begin
          owner_d      = grant;
          last_owner_d = grant;
          cnt_d        = LAT_W'(RD_LAT);
          state_d      = ACCESS;
          // The DM drive registers double as the payload latch, so the memory sees
          // the address/data/enable from the first ACCESS cycle with no req->DM path.
          if (grant == OWN_CPU) begin
            we_d       = bus.cpu_we;
            dm_en_d    = bus.cpu_we;
            dm_addr_d  = bus.cpu_addr;
            dm_wdata_d = bus.cpu_wdata;
          end else begin
            we_d       = bus.ext_we;
            dm_en_d    = bus.ext_we;
            dm_addr_d  = bus.ext_addr;
            dm_wdata_d = bus.ext_wdata;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (!we_q) begin
            if (owner_q == OWN_CPU) cpu_rdata_d = bus.DM_Read_Data;
            else                    ext_rdata_d = bus.DM_Read_Data;
          end
          dm_addr_d  = '0;
          dm_en_d    = 1'b0;
          dm_wdata_d = '0;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Acks are decoded from registered state only.
  assign cpu_ack_w         = (state_q == DONE) && (owner_q == OWN_CPU);
  assign ext_ack_w         = (state_q == DONE) && (owner_q == OWN_EXT);
  assign bus.cpu_ack       = cpu_ack_w;
  assign bus.ext_ack       = ext_ack_w;
  assign bus.cpu_stall     = bus.cpu_req & ~cpu_ack_w;
  assign bus.cpu_rdata     = cpu_rdata_q;
  assign bus.ext_rdata     = ext_rdata_q;
  assign bus.DM_Address    = dm_addr_q;
  assign bus.DM_enable     = dm_en_q;
  assign bus.DM_Write_Data = dm_wdata_q;

`ifndef SYNTHESIS
  // A requester must hold req until its ack; the access still completes if it does not.
  always @(posedge clk) begin
    if (!rst && (state_q == ACCESS)) begin
      assert ((owner_q == OWN_CPU) ? bus.cpu_req : bus.ext_req)
        else $warning("dm_access_arbiter: owner dropped req during an access");
    end
  end
`endif

endmodule

// File: tb/tb_dm_access_arbiter.sv
module tb_dm_access_arbiter;
  import dm_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_access_arbiter_if #(.data_size(32), .mem_size(16)) b1 ();
  dm_access_arbiter_if #(.data_size(32), .mem_size(16)) b0 ();
  dm_access_arbiter_if #(.data_size(32), .mem_size(16)) b3 ();
  dm_access_arbiter_if #(.data_size(32), .mem_size(16)) b7 ();

  dm_access_arbiter #(.data_size(32), .mem_size(16), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  dm_access_arbiter #(.data_size(32), .mem_size(16), .RD_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  dm_access_arbiter #(.data_size(32), .mem_size(16), .RD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));
  dm_access_arbiter #(.data_size(32), .mem_size(16), .RD_LAT(7)) dut7 (.clk(clk), .rst(rst), .bus(b7.slave));

  // Memory with one cycle of read latency behind the RD_LAT=1 instance.
  logic [31:0] mem [0:63];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (b1.DM_enable) mem[b1.DM_Address[5:0]] <= b1.DM_Write_Data;
    rd_q <= mem[b1.DM_Address[5:0]];
  end
  assign b1.DM_Read_Data = rd_q;
  assign b0.DM_Read_Data = 32'h0BAD_F00D;
  assign b3.DM_Read_Data = 32'h3333_0003;
  assign b7.DM_Read_Data = 32'h7777_0007;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          ext;
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  task automatic access1(input bit ext, input bit we, input logic [15:0] addr, input logic [31:0] wd,
                         output int lat, output bit saw_en, output logic [15:0] a1,
                         output logic [31:0] w1, output bit stall1, output bit ack_after);
    @(negedge clk);
    if (ext) begin
      b1.ext_req = 1'b1; b1.ext_we = we; b1.ext_addr = addr; b1.ext_wdata = wd;
    end else begin
      b1.cpu_req = 1'b1; b1.cpu_we = we; b1.cpu_addr = addr; b1.cpu_wdata = wd;
    end
    lat = -1; saw_en = 1'b0; a1 = 'x; w1 = 'x; stall1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin a1 = b1.DM_Address; w1 = b1.DM_Write_Data; stall1 = b1.cpu_stall; end
      if (b1.DM_enable) saw_en = 1'b1;
      if (ext ? b1.ext_ack : b1.cpu_ack) begin lat = k; break; end
    end
    b1.cpu_req = 1'b0; b1.ext_req = 1'b0;
    @(posedge clk); #1;
    ack_after = ext ? b1.ext_ack : b1.cpu_ack;
  endtask

  initial begin
    int lat; bit saw_en; logic [15:0] a1; logic [31:0] w1; bit stall1; bit ack_after;
    logic [31:0] other;
    int ca, ea, nc, ne, acks, alt_bad, nack, addr_bad, hits;
    bit c_rearm, e_rearm, prev_valid; owner_e prev;
    logic en1; logic [15:0] addr1;

    //            ext   we    addr      wdata          expected own rdata
    vecs[0] = '{1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b1, 16'h0008, 32'hCAFE0008, 32'h0000_0000};
    vecs[2] = '{1'b0, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 16'h0020, 32'hA5A55A5A, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 16'h0020, 32'h0,        32'hA5A55A5A};
    vecs[5] = '{1'b1, 1'b0, 16'h0008, 32'h0,        32'hCAFE0008};
    vecs[6] = '{1'b0, 1'b0, 16'h0020, 32'h0,        32'hA5A55A5A};
    vecs[7] = '{1'b0, 1'b1, 16'h0010, 32'h01234567, 32'hA5A55A5A};
    vecs[8] = '{1'b1, 1'b0, 16'h0010, 32'h0,        32'h01234567};
    vecs[9] = '{1'b0, 1'b0, 16'h0008, 32'h0,        32'hCAFE0008};

    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
    b1.ext_req = 0; b1.ext_we = 0; b1.ext_addr = 0; b1.ext_wdata = 0;
    b0.cpu_req = 0; b0.cpu_we = 0; b0.cpu_addr = 0; b0.cpu_wdata = 0;
    b0.ext_req = 0; b0.ext_we = 0; b0.ext_addr = 0; b0.ext_wdata = 0;
    b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = 0; b3.cpu_wdata = 0;
    b3.ext_req = 0; b3.ext_we = 0; b3.ext_addr = 0; b3.ext_wdata = 0;
    b7.cpu_req = 0; b7.cpu_we = 0; b7.cpu_addr = 0; b7.cpu_wdata = 0;
    b7.ext_req = 0; b7.ext_we = 0; b7.ext_addr = 0; b7.ext_wdata = 0;

    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_cpu_ack",   32'(b1.cpu_ack), 32'h0);
    chk("rst_ext_ack",   32'(b1.ext_ack), 32'h0);
    chk("rst_cpu_rdata", b1.cpu_rdata, 32'h0);
    chk("rst_ext_rdata", b1.ext_rdata, 32'h0);
    chk("rst_dm_addr",   32'(b1.DM_Address), 32'h0);
    chk("rst_dm_en",     32'(b1.DM_enable), 32'h0);
    chk("rst_dm_wdata",  b1.DM_Write_Data, 32'h0);

    // Single accesses, one requester at a time.
    for (int i = 0; i < 10; i++) begin
      other = vecs[i].ext ? b1.cpu_rdata : b1.ext_rdata;
      access1(vecs[i].ext, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, saw_en, a1, w1, stall1, ack_after);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d_rdata", i), vecs[i].ext ? b1.ext_rdata : b1.cpu_rdata, vecs[i].exp_rd);
      chk($sformatf("v%0d_other_rdata", i), vecs[i].ext ? b1.cpu_rdata : b1.ext_rdata, other);
      chk($sformatf("v%0d_dm_enable_seen", i), 32'(saw_en), 32'(vecs[i].we));
      chk($sformatf("v%0d_dm_addr", i), 32'(a1), 32'(vecs[i].addr));
      if (vecs[i].we) chk($sformatf("v%0d_dm_wdata", i), w1, vecs[i].wdata);
      chk($sformatf("v%0d_cpu_stall", i), 32'(stall1), vecs[i].ext ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_ack_one_cycle", i), 32'(ack_after), 32'd0);
    end

    // Simultaneous CPU write and external read.
    @(negedge clk);
    b1.cpu_req = 1; b1.cpu_we = 1; b1.cpu_addr = 16'h0004; b1.cpu_wdata = 32'h12345678;
    b1.ext_req = 1; b1.ext_we = 0; b1.ext_addr = 16'h0008; b1.ext_wdata = 32'h0;
    ca = -1; ea = -1; en1 = 1'bx; addr1 = 'x;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin en1 = b1.DM_enable; addr1 = b1.DM_Address; end
      if (b1.cpu_ack && ca < 0) begin ca = k; b1.cpu_req = 0; end
      if (b1.ext_ack && ea < 0) begin ea = k; b1.ext_req = 0; end
      if (ca > 0 && ea > 0) break;
    end
    b1.cpu_req = 0; b1.ext_req = 0;
    @(posedge clk); #1;
`ifdef DM_ARB_ROUND_ROBIN_EN
    chk("tie_first_dm_en",   32'(en1), 32'd0);
    chk("tie_first_dm_addr", 32'(addr1), 32'h0008);
    chk("tie_ext_ack_cycle", 32'(ea), 32'd3);
    chk("tie_cpu_ack_cycle", 32'(ca), 32'd7);
`else
    chk("tie_first_dm_en",   32'(en1), 32'd1);
    chk("tie_first_dm_addr", 32'(addr1), 32'h0004);
    chk("tie_cpu_ack_cycle", 32'(ca), 32'd3);
    chk("tie_ext_ack_cycle", 32'(ea), 32'd7);
`endif
    chk("tie_ext_rdata", b1.ext_rdata, 32'hCAFE0008);
    chk("tie_cpu_rdata_kept", b1.cpu_rdata, 32'hCAFE0008);
    chk("tie_mem_written", mem[4], 32'h12345678);

    // Both requesters re-request continuously for 20 accesses.
    @(negedge clk);
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 16'h0020;
    b1.ext_req = 1; b1.ext_we = 0; b1.ext_addr = 16'h0008;
    nc = 0; ne = 0; acks = 0; alt_bad = 0; c_rearm = 0; e_rearm = 0; prev_valid = 0; prev = OWN_CPU;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (c_rearm) begin b1.cpu_req = 1; c_rearm = 0; end
      if (e_rearm) begin b1.ext_req = 1; e_rearm = 0; end
      if (b1.cpu_ack) begin
        nc++; acks++; b1.cpu_req = 0; c_rearm = 1;
        if (prev_valid && prev == OWN_CPU) alt_bad++;
        prev = OWN_CPU; prev_valid = 1;
      end
      if (b1.ext_ack) begin
        ne++; acks++; b1.ext_req = 0; e_rearm = 1;
        if (prev_valid && prev == OWN_EXT) alt_bad++;
        prev = OWN_EXT; prev_valid = 1;
      end
      if (acks >= 20) break;
    end
    b1.cpu_req = 0; b1.ext_req = 0;
    repeat (2) @(posedge clk); #1;
    chk("stream_total_acks", 32'(acks), 32'd20);
`ifdef DM_ARB_ROUND_ROBIN_EN
    chk("stream_cpu_acks", 32'(nc), 32'd10);
    chk("stream_ext_acks", 32'(ne), 32'd10);
    chk("stream_alternation", 32'(alt_bad), 32'd0);
`else
    chk("stream_cpu_acks", 32'(nc), 32'd20);
    chk("stream_ext_acks", 32'(ne), 32'd0);
`endif

    // External requester drops req in the middle of its read.
    @(negedge clk);
    b1.ext_req = 1; b1.ext_we = 0; b1.ext_addr = 16'h0010;
    @(posedge clk); #1;
    b1.ext_req = 0;
    nack = 0; ea = -1; nc = 0;
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk); #1;
      if (b1.ext_ack) begin nack++; if (ea < 0) ea = k; end
      if (b1.cpu_ack) nc++;
    end
    chk("drop_ext_ack_cycle", 32'(ea), 32'd3);
    chk("drop_ext_ack_count", 32'(nack), 32'd1);
    chk("drop_ext_rdata", b1.ext_rdata, 32'h01234567);
    chk("drop_cpu_no_ack", 32'(nc), 32'd0);

    // Latency extremes: RD_LAT=0 and RD_LAT=7.
    @(negedge clk);
    b0.cpu_req = 1; b0.cpu_we = 0; b0.cpu_addr = 16'h0030;
    lat = -1; addr_bad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (b0.cpu_ack) begin lat = k; break; end
      if (b0.DM_Address !== 16'h0030) addr_bad++;
    end
    b0.cpu_req = 0;
    chk("lat0_ack_cycle", 32'(lat), 32'd2);
    chk("lat0_addr_stable", 32'(addr_bad), 32'd0);
    chk("lat0_rdata", b0.cpu_rdata, 32'h0BADF00D);

    @(negedge clk);
    b7.ext_req = 1; b7.ext_we = 0; b7.ext_addr = 16'h0031;
    lat = -1; addr_bad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (b7.ext_ack) begin lat = k; break; end
      if (b7.DM_Address !== 16'h0031) addr_bad++;
    end
    b7.ext_req = 0;
    chk("lat7_ack_cycle", 32'(lat), 32'd9);
    chk("lat7_addr_stable", 32'(addr_bad), 32'd0);
    chk("lat7_rdata", b7.ext_rdata, 32'h77770007);
    chk("lat7_cpu_rdata_kept", b7.cpu_rdata, 32'h0);

    // Reset in the middle of a RD_LAT=3 write.
    @(negedge clk);
    b3.cpu_req = 1; b3.cpu_we = 1; b3.cpu_addr = 16'h0044; b3.cpu_wdata = 32'h0000_55AA;
    repeat (2) begin @(posedge clk); #1; end
    chk("rstmid_dm_en_before", 32'(b3.DM_enable), 32'd1);
    chk("rstmid_dm_addr_before", 32'(b3.DM_Address), 32'h0044);
    #2; rst = 1'b1; #1;
    chk("rstmid_dm_en_async", 32'(b3.DM_enable), 32'd0);
    chk("rstmid_dm_addr", 32'(b3.DM_Address), 32'h0);
    chk("rstmid_dm_wdata", b3.DM_Write_Data, 32'h0);
    b3.cpu_req = 0; b3.cpu_we = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    hits = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (b3.cpu_ack || b3.ext_ack || b3.DM_enable) hits++;
    end
    chk("rstmid_no_ack", 32'(hits), 32'd0);
    chk("rstmid_b1_cpu_rdata", b1.cpu_rdata, 32'h0);
    chk("rstmid_b1_ext_rdata", b1.ext_rdata, 32'h0);

    @(negedge clk);
    b3.cpu_req = 1; b3.cpu_we = 0; b3.cpu_addr = 16'h0048;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (b3.cpu_ack) begin lat = k; break; end
    end
    b3.cpu_req = 0;
    chk("rstmid_next_ack_cycle", 32'(lat), 32'd5);
    chk("rstmid_next_rdata", b3.cpu_rdata, 32'h33330003);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
